mul_div_wb_arb: RTL



---
 rtl/mul_div_wb_arb_pkg.sv | 19 +
 rtl/wb_result_fifo.sv | 58 +++++
 rtl/mul_div_wb_arb.sv | 131 +++++++++++++
 3 files changed

// File: rtl/mul_div_wb_arb_pkg.sv
// Shared widths and source encoding for the mul/div writeback arbiter.
// Provides default `WORD_WIDTH / `ROB_DEPTH when the build does not define them.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
`ifndef ROB_DEPTH
`define ROB_DEPTH 32
`endif

package mul_div_wb_arb_pkg;
  localparam int unsigned WORD_WIDTH      = `WORD_WIDTH;
  localparam int unsigned PADDR_WIDTH_DEF = $clog2(`ROB_DEPTH);
  localparam int unsigned WB_ENTRY_WIDTH  = WORD_WIDTH + PADDR_WIDTH_DEF;

  typedef enum logic {
    SRC_MUL = 1'b0,
    SRC_DIV = 1'b1
  } wb_src_e;
endpackage

// File: rtl/wb_result_fifo.sv
// Per-source result FIFO: no bypass, push+pop legal at any count, flush has priority.
module wb_result_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign count   = count_q;
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty && !flush;
  // When full, a same-cycle pop frees the slot being overwritten.
  assign do_push = push && !flush && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  overflow_a: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && full && !pop && !flush));

endmodule

// File: rtl/mul_div_wb_arb.sv
// Writeback arbiter for the multiply and divide units onto one valid/ready port.
// Optional: define MUL_DIV_WB_RR_EN for round-robin on conflict (default: mul over div).
module mul_div_wb_arb
  import mul_div_wb_arb_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 2,
  parameter int unsigned PADDR_WIDTH = PADDR_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic [WORD_WIDTH-1:0]  mul_out,
  input  logic                   mul_out_valid,
  input  logic [PADDR_WIDTH-1:0] mul_dst_Paddr,
  input  logic [WORD_WIDTH-1:0]  div_out,
  input  logic                   div_out_valid,
  input  logic [PADDR_WIDTH-1:0] div_dst_Paddr,
  input  logic                   wb_ready,
  output logic                   wb_valid,
  output logic [WORD_WIDTH-1:0]  wb_data,
  output logic [PADDR_WIDTH-1:0] wb_Paddr,
  output logic                   mul_wb_stall,
  output logic                   div_wb_stall
);

  localparam int unsigned ENTRY_W = WORD_WIDTH + PADDR_WIDTH;
  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;

  logic [ENTRY_W-1:0] mul_head;
  logic [ENTRY_W-1:0] div_head;
  logic [ENTRY_W-1:0] sel_head;
  logic               mul_empty;
  logic               div_empty;
  logic               mul_full;
  logic               div_full;
  logic [CNT_W-1:0]   mul_count;
  logic [CNT_W-1:0]   div_count;
  logic               mul_pop;
  logic               div_pop;
  logic               lock_q;
  wb_src_e            grant_q;
  wb_src_e            grant;
`ifdef MUL_DIV_WB_RR_EN
  wb_src_e            last_grant_q;
`endif

  wb_result_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ENTRY_W)) u_mul_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (mul_out_valid),
    .push_data ({mul_out, mul_dst_Paddr}),
    .pop       (mul_pop),
    .flush     (flush),
    .head      (mul_head),
    .empty     (mul_empty),
    .full      (mul_full),
    .count     (mul_count)
  );

  wb_result_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ENTRY_W)) u_div_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (div_out_valid),
    .push_data ({div_out, div_dst_Paddr}),
    .pop       (div_pop),
    .flush     (flush),
    .head      (div_head),
    .empty     (div_empty),
    .full      (div_full),
    .count     (div_count)
  );

  // Grant selection: a stalled offer keeps its source until accepted.
  always_comb begin
    grant = SRC_DIV;
    if (lock_q) begin
      grant = grant_q;
    end else if (!mul_empty && !div_empty) begin
`ifdef MUL_DIV_WB_RR_EN
      grant = (last_grant_q == SRC_MUL) ? SRC_DIV : SRC_MUL;
`else
      grant = SRC_MUL;
`endif
    end else if (!mul_empty) begin
      grant = SRC_MUL;
    end
  end

  always_comb begin
    wb_valid = (grant == SRC_MUL) ? !mul_empty : !div_empty;
    sel_head = (grant == SRC_MUL) ? mul_head : div_head;
    wb_data  = '0;
    wb_Paddr = '0;
    if (wb_valid) begin
      wb_data  = sel_head[ENTRY_W-1:PADDR_WIDTH];
      wb_Paddr = sel_head[PADDR_WIDTH-1:0];
    end
    mul_pop = wb_valid && wb_ready && (grant == SRC_MUL);
    div_pop = wb_valid && wb_ready && (grant == SRC_DIV);
  end

  // Stall leaves one slot for a result already in flight.
  assign mul_wb_stall = mul_full || (mul_count == CNT_W'(FIFO_DEPTH - 1));
  assign div_wb_stall = div_full || (div_count == CNT_W'(FIFO_DEPTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q  <= 1'b0;
      grant_q <= SRC_DIV;
    end else if (flush) begin
      lock_q  <= 1'b0;
      grant_q <= SRC_DIV;
    end else begin
      lock_q  <= wb_valid && !wb_ready;
      grant_q <= grant;
    end
  end

`ifdef MUL_DIV_WB_RR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= SRC_DIV;
    end else if (flush) begin
      last_grant_q <= SRC_DIV;
    end else if (wb_valid && wb_ready) begin
      last_grant_q <= grant;
    end
  end
`endif

endmodule
